// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, FSM encodings and queue entry type for the fetch stage
//   word_t / byte_t / inst_t : word, RAM data and instruction widths
//   fetch_state_e            : FETCH_IDLE, FETCH_BUSY (byte walk), FETCH_LAST (final byte + push)
//   queue_entry_t            : {pc, inst} as held by inst_queue
package fetch_unit_pkg;
  localparam int WORD_W = 32;
  localparam int RAM_DATA_W = 8;
  localparam int INST_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [RAM_DATA_W-1:0] byte_t;
  typedef logic [INST_W-1:0] inst_t;
  localparam word_t ZERO_WORD = '0;
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_BUSY = 2'd1,
    FETCH_LAST = 2'd2
  } fetch_state_e;
  typedef struct packed {
    word_t pc;
    inst_t inst;
  } queue_entry_t;
  function automatic word_t align_word(input word_t a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/inst_queue.sv
// inst_queue: first-word-fall-through FIFO of {pc, inst} entries
//   clk, rst (async, active-low) ; push/din write ; pop consumes head ; clear empties
//   head is a combinational read of the oldest entry ; valid/full/count report occupancy
module inst_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  queue_entry_t             din,
  output queue_entry_t             head,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  queue_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign valid = count != '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & valid & ~clear;
  // a write into a full queue is only legal when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop) & ~clear;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: byte-serial instruction fetch assembling little-endian words into a PC-tagged queue
//   clk, rst (async, active-low)
//   mc_ready_in, mc_rw_signal_out, mc_address_out, mc_data_in : memory controller read port
//   flush_in, flush_pc_in : redirect to a word-aligned target, emptying the queue
//   inst_valid_out, inst_out, inst_pc_out, dec_ready_in : FWFT head towards the decoder
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC = ZERO_WORD,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  mc_ready_in,
  output logic  mc_rw_signal_out,
  output word_t mc_address_out,
  input  byte_t mc_data_in,
  input  logic  flush_in,
  input  word_t flush_pc_in,
  output logic  inst_valid_out,
  output word_t inst_out,
  output word_t inst_pc_out,
  input  logic  dec_ready_in
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  fetch_state_e state;
  logic [1:0] idx;
  word_t fetch_pc;
  logic [2:0][RAM_DATA_W-1:0] lanes;
  logic push, pop, q_full, room_after, can_start;
  logic [CW-1:0] q_count, post_count;
  queue_entry_t q_head;
  assign push = state == FETCH_LAST && mc_ready_in && !flush_in;
  assign pop = inst_valid_out & dec_ready_in & ~flush_in;
  assign post_count = q_count + CW'(push) - CW'(pop);
  assign room_after = post_count < CW'(QUEUE_DEPTH);
  // a pop this cycle frees a slot, so a full queue may still start fetching
  assign can_start = mc_ready_in & (~q_full | pop);
  assign mc_rw_signal_out = 1'b0;
  assign mc_address_out = state == FETCH_BUSY ? fetch_pc + {30'd0, idx} : fetch_pc;
  assign inst_out = q_head.inst;
  assign inst_pc_out = q_head.pc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH_IDLE;
      idx <= '0;
      fetch_pc <= RESET_PC;
      lanes <= '0;
    end else if (flush_in) begin
      state <= FETCH_IDLE;
      idx <= '0;
      fetch_pc <= align_word(flush_pc_in);
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (can_start) begin
            state <= FETCH_BUSY;
            idx <= '0;
          end
        end
        FETCH_BUSY: begin
          if (!mc_ready_in) state <= FETCH_IDLE;
          else begin
            // data for byte idx-1 arrives while byte idx is being addressed
            lanes <= idx == 2'd1 ? {lanes[2:1], mc_data_in} :
                     idx == 2'd2 ? {lanes[2], mc_data_in, lanes[0]} :
                     idx == 2'd3 ? {mc_data_in, lanes[1:0]} : lanes;
            if (idx == 2'd3) state <= FETCH_LAST;
            else idx <= idx + 2'd1;
          end
        end
        FETCH_LAST: begin
          if (!mc_ready_in) state <= FETCH_IDLE;
          else begin
            fetch_pc <= fetch_pc + 32'd4;
            idx <= '0;
            state <= room_after ? FETCH_BUSY : FETCH_IDLE;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end
  inst_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush_in),
    .din   ('{pc: fetch_pc, inst: {mc_data_in, lanes}}),
    .head  (q_head),
    .valid (inst_valid_out),
    .full  (q_full),
    .count (q_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a byte memory model
module tb_fetch_unit;
  logic clk = 0;
  logic rst;
  logic mc_ready_in;
  logic mc_rw_signal_out;
  logic [31:0] mc_address_out;
  logic [7:0] mc_data_in;
  logic flush_in;
  logic [31:0] flush_pc_in;
  logic inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic dec_ready_in;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .mc_ready_in      (mc_ready_in),
    .mc_rw_signal_out (mc_rw_signal_out),
    .mc_address_out   (mc_address_out),
    .mc_data_in       (mc_data_in),
    .flush_in         (flush_in),
    .flush_pc_in      (flush_pc_in),
    .inst_valid_out   (inst_valid_out),
    .inst_out         (inst_out),
    .inst_pc_out      (inst_pc_out),
    .dec_ready_in     (dec_ready_in)
  );
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0: return 8'h13;
      32'd1: return 8'h05;
      32'd2: return 8'h10;
      32'd3: return 8'h00;
      default: return a[7:0] ^ 8'h5A ^ a[31:24];
    endcase
  endfunction
  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return {mem_byte(pc + 3), mem_byte(pc + 2), mem_byte(pc + 1), mem_byte(pc)};
  endfunction
  always @(posedge clk) mc_data_in <= mem_byte(mc_address_out);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(inst_valid_out), 32'd1);
    check({tag, "_pc"}, inst_pc_out, pc);
    check({tag, "_inst"}, inst_out, exp_inst(pc));
  endtask
  initial begin
    rst = 0;
    mc_ready_in = 1;
    flush_in = 0;
    flush_pc_in = 0;
    dec_ready_in = 0;
    #3;
    check("rst_valid", 32'(inst_valid_out), 32'd0);
    check("rst_rw", 32'(mc_rw_signal_out), 32'd0);
    check("rst_addr", mc_address_out, 32'd0);
    step(2);
    rst = 1;
    step();
    check("a_addr0", mc_address_out, 32'd0);
    step();
    check("a_addr1", mc_address_out, 32'd1);
    step();
    check("a_addr2", mc_address_out, 32'd2);
    step();
    check("a_addr3", mc_address_out, 32'd3);
    step();
    check("a_last_addr", mc_address_out, 32'd0);
    check("a_last_valid", 32'(inst_valid_out), 32'd0);
    step();
    check_head("a_head0", 32'd0);
    check("a_inst_const", inst_out, 32'h00100513);
    check("a_next_addr", mc_address_out, 32'd4);
    step(15);
    check("full_addr", mc_address_out, 32'd16);
    check_head("full_head", 32'd0);
    step(2);
    check("full_idle_addr", mc_address_out, 32'd16);
    check("full_rw", 32'(mc_rw_signal_out), 32'd0);
    dec_ready_in = 1;
    step();
    dec_ready_in = 0;
    check_head("pop_head", 32'd4);
    check("pop_restart_addr", mc_address_out, 32'd16);
    step();
    check("pop_restart_addr1", mc_address_out, 32'd17);
    step(4);
    check("refull_addr", mc_address_out, 32'd20);
    dec_ready_in = 1;
    step();
    dec_ready_in = 0;
    check_head("pp_head8", 32'd8);
    check("pp_fetch20", mc_address_out, 32'd20);
    step(4);
    check("pp_last_addr", mc_address_out, 32'd20);
    dec_ready_in = 1;
    step();
    dec_ready_in = 0;
    check_head("pp_head12", 32'd12);
    check("pp_addr24", mc_address_out, 32'd24);
    step();
    check("pp_addr25", mc_address_out, 32'd25);
    step(4);
    check("pp_idle28", mc_address_out, 32'd28);
    step();
    check("pp_idle28b", mc_address_out, 32'd28);
    check_head("ord_12", 32'd12);
    dec_ready_in = 1;
    step();
    check_head("ord_16", 32'd16);
    check("ord_fetch28", mc_address_out, 32'd28);
    step();
    dec_ready_in = 0;
    check_head("ord_20", 32'd20);
    check("ord_addr29", mc_address_out, 32'd29);
    step();
    check("fl_idx2_addr", mc_address_out, 32'd30);
    flush_in = 1;
    flush_pc_in = 32'h103;
    step();
    flush_in = 0;
    check("fl_valid_drop", 32'(inst_valid_out), 32'd0);
    check("fl_idle_addr", mc_address_out, 32'h100);
    for (int k = 0; k < 4; k++) begin
      step();
      check("fl_addr", mc_address_out, 32'h100 + k);
    end
    step();
    check("fl_last_valid", 32'(inst_valid_out), 32'd0);
    step();
    check_head("fl_head", 32'h100);
    step();
    rst = 0;
    #1;
    check("ar_valid", 32'(inst_valid_out), 32'd0);
    check("ar_addr", mc_address_out, 32'd0);
    check("ar_rw", 32'(mc_rw_signal_out), 32'd0);
    step();
    rst = 1;
    dec_ready_in = 1;
    step();
    check("ar_restart_addr", mc_address_out, 32'd0);
    step(5);
    check_head("ar_head0", 32'd0);
    step(5);
    check_head("rdy_head4", 32'd4);
    check("rdy_addr8", mc_address_out, 32'd8);
    step(2);
    check("rdy_addr10", mc_address_out, 32'd10);
    mc_ready_in = 0;
    step();
    mc_ready_in = 1;
    check("rdy_idle_addr", mc_address_out, 32'd8);
    check("rdy_idle_valid", 32'(inst_valid_out), 32'd0);
    step(2);
    check("rdy_refetch9", mc_address_out, 32'd9);
    check("rdy_nopush", 32'(inst_valid_out), 32'd0);
    step(4);
    check_head("rdy_head8", 32'd8);
    flush_in = 1;
    flush_pc_in = 32'hFFFF_FFFE;
    step();
    flush_in = 0;
    check("wr_valid", 32'(inst_valid_out), 32'd0);
    check("wr_idle_addr", mc_address_out, 32'hFFFF_FFFC);
    step();
    check("wr_addr0", mc_address_out, 32'hFFFF_FFFC);
    step(3);
    check("wr_addr3", mc_address_out, 32'hFFFF_FFFF);
    step();
    check("wr_last_addr", mc_address_out, 32'hFFFF_FFFC);
    step();
    check_head("wr_head", 32'hFFFF_FFFC);
    check("wr_wrap_addr", mc_address_out, 32'd0);
    step(5);
    check_head("wr_head0", 32'd0);
    check("wr_inst_const", inst_out, 32'h00100513);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
